tspi_obi_arbiter: RTL
=====================

Name: tspi_obi_arbiter

Overview:
- Dynamic two-requester arbiter in front of the single tspi_host OBI subordinate port.
- Requesters: the core's transparent-SPI OBI path (from the user demux) and block_swap_ctrl's SD-card OBI path.
- Replaces the static block_swap_on mux; the core can still reach the SD card between swap transactions.
- Exactly one transaction outstanding on the tspi port; swap has priority; core is protected by a starvation counter; a lock input holds core requests during an active swap sequence.

Parameters:
- obi_req_t, sbr_obi_req_t: OBI request struct type.
- obi_rsp_t, sbr_obi_rsp_t: OBI response struct type.
- MaxCoreWait, 16: cycles a pending unlocked core request may lose arbitration before it is forced to win.
- TimeoutCycles, 1024: response watchdog limit (only with TSPI_ARB_TIMEOUT_EN).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- core_req_i  in  obi_req_t  core transparent-SPI request
- core_rsp_o  out  obi_rsp_t  response to core
- swap_req_i  in  obi_req_t  block_swap_ctrl SD-card request
- swap_rsp_o  out  obi_rsp_t  response to block_swap_ctrl
- tspi_req_o  out  obi_req_t  to tspi_host
- tspi_rsp_i  in  obi_rsp_t  from tspi_host
- swap_lock_i  in  1  high while a block swap sequence runs; core not granted
- busy_o  out  1  a transaction is outstanding
- owner_o  out  1  owner of the outstanding transaction; 0=core, 1=swap
- timeout_o  out  1  one-cycle watchdog pulse

Behaviour:
- Single clock domain: clk_i. Reset asynchronous, active-low (rst_ni).
- Reset values: all outputs 0, including req/gnt/rvalid/rdata/err; state IDLE; starvation count 0.
- FSM states: IDLE, CORE_WAIT, SWAP_WAIT.
- IDLE arbitration (combinational, same cycle):
  - core_eligible = core.req & ~swap_lock_i.
  - Select swap if swap.req and not (core_eligible and starve_cnt == MaxCoreWait).
  - Otherwise select core if core_eligible.
- IDLE forwarding:
  - Selected requester's a-channel and req drive tspi_req_o; tspi gnt is routed back only to the selected requester.
  - The non-selected requester sees gnt=0 and must hold its request (OBI stability).
- IDLE transitions: on tspi gnt, go to CORE_WAIT or SWAP_WAIT; owner_o and busy_o are registered and valid from the next cycle.
- *_WAIT:
  - tspi_req_o.req=0 and both gnt=0.
  - tspi rvalid, rdata, err and rid are routed to the owner only; the other requester's rvalid stays 0.
  - On rvalid, return to IDLE. The earliest next grant is the cycle after rvalid (no same-cycle regrant).
- Latency: zero added on the request path; zero added on the response path; minimum 2 cycles between grants.
- Starvation counter:
  - Increments each cycle core_eligible is high and core is not granted.
  - Saturates at MaxCoreWait.
  - Clears on core grant or when core_eligible is low.
  - Width is $clog2(MaxCoreWait+1).
- Simultaneous requests: swap wins unless the counter is saturated.
- swap_lock_i:
  - Rising while CORE_WAIT does not abort; the core response is still delivered.
  - Only new core grants are blocked.
  - A locked core request is held, not errored, and does not advance the counter.
- Stray tspi rvalid in IDLE: dropped, never forwarded.
- Reset mid-transaction: FSM goes to IDLE immediately and any in-flight response is lost. Requesters are reset by the same rst_ni.

Optional Feature:
- Macro: TSPI_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in *_WAIT and clears on entry.
  - When it reaches TimeoutCycles without tspi rvalid, the arbiter sends rvalid=1, err=1, rdata=32'hBADCAB1E and the latched aid as rid to the owner.
  - It pulses timeout_o for one cycle and returns to IDLE.
  - A later rvalid from tspi_host is treated as stray and dropped.
- Undefined: no counter; *_WAIT lasts until rvalid; timeout_o tied 0.

Decomposition:
- user_pkg additions:
  - enum tspi_arb_state_e {IDLE, CORE_WAIT, SWAP_WAIT}.
  - tspi_arb_owner_e {TspiOwnerCore=0, TspiOwnerSwap=1}.
  - localparam TspiArbTimeoutData = 32'hBADCAB1E.
- Sub-module tspi_arb_watchdog: timeout counter with clear/enable/expire. Instantiated only under the macro.

Test Plan:
1. Core-only read of addr 0x0 with tspi rvalid 3 cycles after gnt → core_rsp rvalid with tspi rdata; swap_rsp rvalid never asserted; owner_o=0; busy_o high for 3 cycles.
2. Core and swap request in the same cycle, counter 0 → swap granted first. Core granted the cycle after swap rvalid. No response crosses to the wrong requester.
3. Swap requests back-to-back, core held for 20 cycles, MaxCoreWait=16 → core wins the arbitration after the counter reaches 16; the counter returns to 0 after the core grant.
4. swap_lock_i=1 with core req high for 50 cycles → core gnt stays 0 and the counter stays 0. Lock drops → core granted the same cycle.
5. rst_ni pulled low in SWAP_WAIT, then the late tspi rvalid arrives after reset → all outputs 0 during reset; the rvalid is dropped; the next core request is granted normally.
6. (TSPI_ARB_TIMEOUT_EN, TimeoutCycles=8) Swap write with tspi never responding → on the 8th WAIT cycle, swap_rsp shows rvalid=1, err=1, rdata=0xBADCAB1E; timeout_o pulses once; FSM returns to IDLE.

Source files
------------

// File: rtl/tspi_obi_arbiter_pkg.sv
// Shared types for the tspi OBI arbiter: FSM state, owner encoding, the
// default OBI request/response structs and the watchdog error payload.
package tspi_obi_arbiter_pkg;

    localparam int unsigned TspiAidWidth = 4;

    // rdata returned to the owner when the watchdog gives up on tspi_host
    localparam logic [31:0] TspiArbTimeoutData = 32'hBADCAB1E;

    typedef enum logic [1:0] {
        IDLE,
        CORE_WAIT,
        SWAP_WAIT
    } tspi_arb_state_e;

    typedef enum logic {
        TspiOwnerCore = 1'b0,
        TspiOwnerSwap = 1'b1
    } tspi_arb_owner_e;

    typedef struct packed {
        logic                    req;
        logic [31:0]             addr;
        logic                    we;
        logic [3:0]              be;
        logic [31:0]             wdata;
        logic [TspiAidWidth-1:0] aid;
    } tspi_obi_req_t;

    typedef struct packed {
        logic                    gnt;
        logic                    rvalid;
        logic [31:0]             rdata;
        logic                    err;
        logic [TspiAidWidth-1:0] rid;
    } tspi_obi_rsp_t;

endpackage

// File: rtl/tspi_arb_watchdog.sv
// Response watchdog for the tspi arbiter: counts cycles while enabled,
// restarts on clear, and flags expiry on the TimeoutCycles-th enabled cycle.
// Only instantiated when TSPI_ARB_TIMEOUT_EN is defined.
module tspi_arb_watchdog #(
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

    logic [CntW-1:0] cnt_q;

    // Cycle counter; holds at the expiry value until cleared
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (enable_i && !expire_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Expiry flag for the current cycle
    always_comb begin
        expire_o = enable_i && (cnt_q == CntW'(TimeoutCycles - 1));
    end

endmodule

// File: rtl/tspi_obi_arbiter.sv
// Two-requester arbiter (core transparent-SPI path vs block_swap_ctrl) in
// front of the single tspi_host OBI port. One transaction outstanding, swap
// has priority, core protected by a starvation counter and blocked while
// swap_lock_i is high. Optional macro TSPI_ARB_TIMEOUT_EN adds a response
// watchdog that answers the owner with an error after TimeoutCycles.
module tspi_obi_arbiter
    import tspi_obi_arbiter_pkg::*;
#(
    parameter type         obi_req_t     = tspi_obi_req_t,
    parameter type         obi_rsp_t     = tspi_obi_rsp_t,
    parameter type         sbr_obi_req_t = obi_req_t,
    parameter type         sbr_obi_rsp_t = obi_rsp_t,
    parameter int unsigned MaxCoreWait   = 16,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  obi_req_t     core_req_i,
    output obi_rsp_t     core_rsp_o,
    input  obi_req_t     swap_req_i,
    output obi_rsp_t     swap_rsp_o,
    output sbr_obi_req_t tspi_req_o,
    input  sbr_obi_rsp_t tspi_rsp_i,
    input  logic         swap_lock_i,
    output logic         busy_o,
    output logic         owner_o,
    output logic         timeout_o
);

    localparam int unsigned StarveW = $clog2(MaxCoreWait + 1);

    tspi_arb_state_e state_q, state_d;
    tspi_arb_owner_e owner;
    logic [StarveW-1:0] starve_q;
    logic core_eligible, starve_sat, sel_swap, sel_core;
    logic core_win, swap_win, timeout_hit;
    obi_req_t a_sel;
    logic rsp_rvalid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [TspiAidWidth-1:0] rsp_rid;

    // IDLE arbitration: swap first unless the waiting core has saturated
    always_comb begin
        core_eligible = core_req_i.req & ~swap_lock_i;
        starve_sat    = (starve_q == StarveW'(MaxCoreWait));
        sel_swap      = swap_req_i.req & ~(core_eligible & starve_sat);
        sel_core      = ~sel_swap & core_eligible;
        a_sel         = sel_swap ? swap_req_i : core_req_i;
        swap_win      = (state_q == IDLE) & sel_swap & tspi_rsp_i.gnt;
        core_win      = (state_q == IDLE) & sel_core & tspi_rsp_i.gnt;
    end

`ifdef TSPI_ARB_TIMEOUT_EN
    logic wd_expire;
    logic [TspiAidWidth-1:0] aid_q;

    tspi_arb_watchdog #(
        .TimeoutCycles(TimeoutCycles)
    ) u_watchdog (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (state_q == IDLE),
        .enable_i(state_q != IDLE),
        .expire_o(wd_expire)
    );

    // Latch the granted aid so a timeout response carries the right rid
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aid_q <= '0;
        end else if (swap_win) begin
            aid_q <= swap_req_i.aid;
        end else if (core_win) begin
            aid_q <= core_req_i.aid;
        end
    end

    // A real rvalid in the expiry cycle wins over the synthetic error
    always_comb begin
        timeout_hit = wd_expire & ~tspi_rsp_i.rvalid;
        timeout_o   = timeout_hit;
    end
`else
    // Without the watchdog a WAIT state lasts until tspi_host answers
    always_comb begin
        timeout_hit = 1'b0;
        timeout_o   = (TimeoutCycles == 0) & 1'b0;
    end
`endif

    // Response payload towards the owner: tspi_host or the timeout error
    always_comb begin
        rsp_rvalid = tspi_rsp_i.rvalid;
        rsp_rdata  = tspi_rsp_i.rdata;
        rsp_err    = tspi_rsp_i.err;
        rsp_rid    = tspi_rsp_i.rid;
`ifdef TSPI_ARB_TIMEOUT_EN
        if (timeout_hit) begin
            rsp_rvalid = 1'b1;
            rsp_rdata  = TspiArbTimeoutData;
            rsp_err    = 1'b1;
            rsp_rid    = aid_q;
        end
`endif
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave IDLE on grant, return on response or timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (swap_win) begin
                    state_d = SWAP_WAIT;
                end else if (core_win) begin
                    state_d = CORE_WAIT;
                end
            end
            CORE_WAIT, SWAP_WAIT: begin
                if (rsp_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: forward the selected a-channel in IDLE, route r-channel to owner
    always_comb begin
        tspi_req_o = '0;
        core_rsp_o = '0;
        swap_rsp_o = '0;
        owner      = (state_q == SWAP_WAIT) ? TspiOwnerSwap : TspiOwnerCore;
        owner_o    = owner;
        busy_o     = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (sel_swap || sel_core) begin
                    tspi_req_o.req   = 1'b1;
                    tspi_req_o.addr  = a_sel.addr;
                    tspi_req_o.we    = a_sel.we;
                    tspi_req_o.be    = a_sel.be;
                    tspi_req_o.wdata = a_sel.wdata;
                    tspi_req_o.aid   = a_sel.aid;
                end
                swap_rsp_o.gnt = sel_swap & tspi_rsp_i.gnt;
                core_rsp_o.gnt = sel_core & tspi_rsp_i.gnt;
            end
            CORE_WAIT: begin
                core_rsp_o.rvalid = rsp_rvalid;
                core_rsp_o.rdata  = rsp_rdata;
                core_rsp_o.err    = rsp_err;
                core_rsp_o.rid    = rsp_rid;
            end
            SWAP_WAIT: begin
                swap_rsp_o.rvalid = rsp_rvalid;
                swap_rsp_o.rdata  = rsp_rdata;
                swap_rsp_o.err    = rsp_err;
                swap_rsp_o.rid    = rsp_rid;
            end
            default: ;
        endcase
    end

    // Starvation counter: counts lost cycles of an eligible core request
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_q <= '0;
        end else if (!core_eligible || core_win) begin
            starve_q <= '0;
        end else if (!starve_sat) begin
            starve_q <= starve_q + 1'b1;
        end
    end

endmodule
